// File: rtl/dmem_map_pkg.sv
// Address map, STATUS layout and address decode shared by the dmem responder.
package dmem_map_pkg;

  // MMIO word addresses
  localparam logic [31:0] ADDR_OUT_DATA = 32'h0000_FFF0;
  localparam logic [31:0] ADDR_STATUS   = 32'h0000_FFF1;
  localparam logic [31:0] ADDR_CYCLE    = 32'h0000_FFF2;

  // STATUS bit indices
  localparam int unsigned ST_FULL     = 0;
  localparam int unsigned ST_EMPTY    = 1;
  localparam int unsigned ST_FAULT    = 2;
  localparam int unsigned ST_OVERFLOW = 3;

  // STATUS count field
  localparam int unsigned COUNT_LSB = 8;
  localparam int unsigned COUNT_W   = 8;

  typedef enum logic [2:0] {
    REGION_RAM,
    REGION_OUT,
    REGION_STATUS,
    REGION_CYCLE,
    REGION_NONE
  } region_e;

  // RAM is checked first so a large RAM shadows the MMIO window rather than aliasing it.
  function automatic region_e decode_region(input logic [31:0] addr,
                                            input int unsigned ram_bits);
    region_e r;
    if ((addr >> ram_bits) == 32'd0) r = REGION_RAM;
    else if (addr == ADDR_OUT_DATA)  r = REGION_OUT;
    else if (addr == ADDR_STATUS)    r = REGION_STATUS;
    else if (addr == ADDR_CYCLE)     r = REGION_CYCLE;
    else                             r = REGION_NONE;
    return r;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Processor dmem port plus the output-FIFO drain port and the fault flag.
interface dmem_responder_if;
  logic [31:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q_dmem;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic        fault;

  // Environment side: drives the dmem access and consumes the FIFO.
  modport master (
    output address_dmem, data, wren, out_ready,
    input  q_dmem, out_valid, out_data, fault
  );

  // Responder side.
  modport slave (
    input  address_dmem, data, wren, out_ready,
    output q_dmem, out_valid, out_data, fault
  );
endinterface

// File: rtl/dmem_responder_out_fifo.sv
// Output FIFO with a registered head (no fall-through) and an overflow pulse.
module out_fifo #(
  parameter  int DEPTH  = 8,
  parameter  int DATA_W = 32,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic              head_valid_o,
  output logic [DATA_W-1:0] head_data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              overflow_o
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              head_valid_q, head_valid_d;
  logic [DATA_W-1:0] head_data_q, head_data_d;
  logic              pop_ok, push_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it.
  assign pop_ok     = pop_i & ~empty_o;
  assign push_ok    = push_i & (~full_o | pop_ok);
  assign overflow_o = push_i & full_o & ~pop_ok;

  // Next pointers, occupancy and head word.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can leave it unassigned and infer a latch.
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    head_data_d = '0;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    head_valid_d = (count_d != '0);
    // The new head is the word being written this cycle when it lands in the head slot.
    if (head_valid_d) begin
      if (push_ok && (wr_ptr_q == rd_ptr_d)) head_data_d = push_data_i;
      else                                   head_data_d = mem[rd_ptr_d];
    end
  end

  // Pointer, count and head registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      head_valid_q <= 1'b0;
      head_data_q  <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      head_valid_q <= head_valid_d;
      head_data_q  <= head_data_d;
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    // NOTE: storage arrays are not reset; validity is tracked by the reset pointers and count.
    if (push_ok) mem[wr_ptr_q] <= push_data_i;
  end

  assign head_valid_o = head_valid_q;
  assign head_data_o  = head_data_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus MMIO output FIFO, cycle counter and status/fault.
module dmem_responder
  import dmem_map_pkg::*;
#(
  parameter int RAM_ADDR_BITS = 12,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic          clock,
  input  logic          reset,
  dmem_responder_if.slave bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [31:0] ram [2**RAM_ADDR_BITS];

  region_e     region;
  logic        ram_we, push, status_wr, cycle_wr, unmapped;
  logic [31:0] status_word;

  logic [31:0] q_dmem_q, q_dmem_d;
  logic [31:0] cycle_q, cycle_d;
  logic        fault_q, fault_d;
  logic        overflow_q, overflow_d;

  logic             fifo_full, fifo_empty, fifo_overflow;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_valid;
  logic [31:0]      fifo_data;

  out_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DATA_W(32)
  ) u_out_fifo (
    .clk         (clock),
    .rst_n       (reset),
    .push_i      (push),
    .push_data_i (bus.data),
    .pop_i       (bus.out_ready),
    .head_valid_o(fifo_valid),
    .head_data_o (fifo_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count),
    .overflow_o  (fifo_overflow)
  );

  // Address decode and per-region strobes; every cycle is one access.
  always_comb begin
    region    = decode_region(bus.address_dmem, RAM_ADDR_BITS);
    ram_we    = bus.wren && (region == REGION_RAM);
    push      = bus.wren && (region == REGION_OUT);
    status_wr = bus.wren && (region == REGION_STATUS);
    cycle_wr  = bus.wren && (region == REGION_CYCLE);
    unmapped  = (region == REGION_NONE);
  end

  // STATUS read image, taken from state before this edge's push/pop.
  always_comb begin
    status_word                          = '0;
    status_word[ST_FULL]                 = fifo_full;
    status_word[ST_EMPTY]                = fifo_empty;
    status_word[ST_FAULT]                = fault_q;
    status_word[ST_OVERFLOW]             = overflow_q;
    status_word[COUNT_LSB +: COUNT_W]    = COUNT_W'(fifo_count);
  end

  // Read-data mux: RAM writes return the written word, MMIO writes and unmapped reads return 0.
  always_comb begin
    q_dmem_d = '0;
    unique case (region)
      REGION_RAM:    q_dmem_d = bus.wren ? bus.data
                                         : ram[bus.address_dmem[RAM_ADDR_BITS-1:0]];
      REGION_STATUS: q_dmem_d = bus.wren ? 32'd0 : status_word;
      REGION_CYCLE:  q_dmem_d = bus.wren ? 32'd0 : cycle_q;
      default:       q_dmem_d = '0;
    endcase
  end

  // Sticky flags with write-1-to-clear (a same-cycle set wins), and the loadable counter.
  always_comb begin
    fault_d    = unmapped
               | (fault_q & ~(status_wr & bus.data[ST_FAULT]));
    overflow_d = fifo_overflow
               | (overflow_q & ~(status_wr & bus.data[ST_OVERFLOW]));
    cycle_d    = cycle_wr ? bus.data : cycle_q + 32'd1;
  end

  // Control and read-data registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q_dmem_q   <= '0;
      cycle_q    <= '0;
      fault_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      q_dmem_q   <= q_dmem_d;
      cycle_q    <= cycle_d;
      fault_q    <= fault_d;
      overflow_q <= overflow_d;
    end
  end

  // RAM write port.
  always_ff @(posedge clock) begin
    if (ram_we) ram[bus.address_dmem[RAM_ADDR_BITS-1:0]] <= bus.data;
  end

  assign bus.q_dmem    = q_dmem_q;
  assign bus.out_valid = fifo_valid;
  assign bus.out_data  = fifo_data;
  assign bus.fault     = fault_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder.
module tb_dmem_responder;

  localparam logic [31:0] A_OUT    = 32'h0000_FFF0;
  localparam logic [31:0] A_STATUS = 32'h0000_FFF1;
  localparam logic [31:0] A_CYCLE  = 32'h0000_FFF2;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  dmem_responder_if bus ();

  dmem_responder #(
    .RAM_ADDR_BITS(12),
    .FIFO_DEPTH   (8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One access: drive, take the rising edge, settle 1 time unit past it.
  task automatic do_cycle(input logic [31:0] addr, input logic [31:0] wdata, input logic we);
    bus.address_dmem = addr;
    bus.data         = wdata;
    bus.wren         = we;
    @(posedge clock);
    #1;
  endtask

  // Idle access: read of OUT_DATA has no side effects and returns 0.
  task automatic idle();
    do_cycle(A_OUT, 32'd0, 1'b0);
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    reset            = 1'b0;
    bus.address_dmem = A_OUT;
    bus.data         = 32'd0;
    bus.wren         = 1'b0;
    bus.out_ready    = 1'b0;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check("rst_q", bus.q_dmem, 32'd0);
    check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_data", bus.out_data, 32'd0);
    check("rst_fault", {31'd0, bus.fault}, 32'd0);
    reset = 1'b1;

    // RAM path, write-first
    do_cycle(32'd5, 32'h1234_5678, 1'b1);
    check("ram_wr_q", bus.q_dmem, 32'h1234_5678);
    do_cycle(32'd6, 32'hDEAD_BEEF, 1'b1);
    check("ram_wr6_q", bus.q_dmem, 32'hDEAD_BEEF);
    do_cycle(32'd5, 32'd0, 1'b0);
    check("ram_rd5", bus.q_dmem, 32'h1234_5678);
    do_cycle(32'd6, 32'd0, 1'b0);
    check("ram_rd6", bus.q_dmem, 32'hDEAD_BEEF);
    do_cycle(32'h0000_0FFF, 32'hCAFE_0001, 1'b1);
    do_cycle(32'h0000_0FFF, 32'd0, 1'b0);
    check("ram_top", bus.q_dmem, 32'hCAFE_0001);
    check("ram_nofault", {31'd0, bus.fault}, 32'd0);

    // FIFO fill to full, overflow, clear
    for (int i = 1; i <= 8; i++) begin
      do_cycle(A_OUT, 32'(i), 1'b1);
      if (i == 1) check("push_q", bus.q_dmem, 32'd0);
    end
    do_cycle(A_STATUS, 32'd0, 1'b0);
    check("st_full", bus.q_dmem, 32'h0000_0801);
    do_cycle(A_OUT, 32'd9, 1'b1);
    do_cycle(A_STATUS, 32'd0, 1'b0);
    check("st_ovf", bus.q_dmem, 32'h0000_0809);
    check("ovf_nofault", {31'd0, bus.fault}, 32'd0);
    do_cycle(A_STATUS, 32'h0000_0008, 1'b1);
    check("st_wr_q", bus.q_dmem, 32'd0);
    do_cycle(A_STATUS, 32'd0, 1'b0);
    check("st_ovf_clr", bus.q_dmem, 32'h0000_0801);
    check("head1", bus.out_data, 32'd1);

    // Drain 1..8
    bus.out_ready = 1'b1;
    for (int i = 2; i <= 8; i++) begin
      idle();
      check($sformatf("drain%0d", i), bus.out_data, 32'(i));
    end
    idle();
    check("drain_valid", {31'd0, bus.out_valid}, 32'd0);
    check("drain_data", bus.out_data, 32'd0);

    // Push and pop together while full
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) do_cycle(A_OUT, 32'h11 + 32'(i), 1'b1);
    bus.out_ready = 1'b1;
    do_cycle(A_OUT, 32'h0000_00AA, 1'b1);
    check("simul_head", bus.out_data, 32'h12);
    do_cycle(A_STATUS, 32'd0, 1'b0);
    check("simul_st", bus.q_dmem, 32'h0000_0801);
    check("simul_head2", bus.out_data, 32'h13);
    for (int v = 'h14; v <= 'h18; v++) begin
      idle();
      check($sformatf("simul_d%0h", v), bus.out_data, 32'(v));
    end
    idle();
    check("simul_last", bus.out_data, 32'h0000_00AA);
    idle();
    check("simul_empty", {31'd0, bus.out_valid}, 32'd0);

    // Push into empty FIFO with ready high: no fall-through
    do_cycle(A_OUT, 32'h55, 1'b1);
    check("ft_valid", {31'd0, bus.out_valid}, 32'd1);
    check("ft_data", bus.out_data, 32'h55);
    idle();
    check("ft_popped", {31'd0, bus.out_valid}, 32'd0);
    bus.out_ready = 1'b0;

    // Cycle counter load and wrap
    do_cycle(A_CYCLE, 32'hFFFF_FFFE, 1'b1);
    check("cyc_wr_q", bus.q_dmem, 32'd0);
    do_cycle(A_CYCLE, 32'd0, 1'b0);
    check("cyc_fe", bus.q_dmem, 32'hFFFF_FFFE);
    do_cycle(A_CYCLE, 32'd0, 1'b0);
    check("cyc_ff", bus.q_dmem, 32'hFFFF_FFFF);
    idle();
    do_cycle(A_CYCLE, 32'd0, 1'b0);
    check("cyc_wrap", bus.q_dmem, 32'd1);

    // Fault set, read back, clear
    do_cycle(32'h0000_8000, 32'd0, 1'b0);
    check("flt_q", bus.q_dmem, 32'd0);
    check("flt_set", {31'd0, bus.fault}, 32'd1);
    do_cycle(A_STATUS, 32'd0, 1'b0);
    check("flt_st", bus.q_dmem, 32'h0000_0006);
    do_cycle(A_STATUS, 32'h0000_0004, 1'b1);
    check("flt_clr", {31'd0, bus.fault}, 32'd0);
    do_cycle(32'h0001_0000, 32'h1, 1'b1);
    check("flt_wr", {31'd0, bus.fault}, 32'd1);
    check("flt_wr_q", bus.q_dmem, 32'd0);

    // Reset mid-drain with fault still set
    for (int i = 0; i < 3; i++) do_cycle(A_OUT, 32'h70 + 32'(i), 1'b1);
    check("pre_rst_valid", {31'd0, bus.out_valid}, 32'd1);
    do_cycle(A_CYCLE, 32'd0, 1'b0);
    reset = 1'b0;
    #2;
    check("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mid_rst_data", bus.out_data, 32'd0);
    check("mid_rst_q", bus.q_dmem, 32'd0);
    check("mid_rst_fault", {31'd0, bus.fault}, 32'd0);
    reset = 1'b1;
    do_cycle(A_STATUS, 32'd0, 1'b0);
    check("post_rst_st", bus.q_dmem, 32'h0000_0002);
    do_cycle(A_CYCLE, 32'd0, 1'b0);
    check("post_rst_cyc", bus.q_dmem, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined processor's dmem port: it receives `address_dmem`, `data` and `wren` and returns `q_dmem` with a fixed one-cycle read latency. Addresses decode to a word-addressed RAM and a small MMIO window. The MMIO window holds an output FIFO with a valid/ready drain port, a free-running cycle counter, and a status/fault register. The block sits in the wrapper between the processor and the external environment.

## Interface
Parameters:
- `RAM_ADDR_BITS`, 12: RAM holds 2^RAM_ADDR_BITS 32-bit words at word addresses 0 .. 2^RAM_ADDR_BITS-1.
- `FIFO_DEPTH`, 8: output FIFO entries; power of two, 2..64.

Ports:
- `clock`  in  1: single clock; all state changes on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `address_dmem`  in  32: word address from the processor.
- `data`  in  32: write data.
- `wren`  in  1: write enable; 1 = write, 0 = read.
- `q_dmem`  out  32: read data, registered.
- `out_valid`  out  1: FIFO head valid.
- `out_data`  out  32: FIFO head word; 0 when empty.
- `out_ready`  in  1: consumer accepts the head.
- `fault`  out  1: sticky; set by any access to an unmapped address.

## Operation
Memory map (word addresses):
- RAM: 0 .. 2^RAM_ADDR_BITS-1, read/write.
- OUT_DATA at 0xFFF0:
  - Write pushes `data` into the FIFO.
  - Read returns 0.
- STATUS at 0xFFF1, read:
  - bit0 full, bit1 empty, bit2 fault, bit3 overflow.
  - [15:8] count, zero-extended.
  - Other bits 0.
- STATUS at 0xFFF1, write-1-to-clear: bit2 clears fault, bit3 clears overflow. Other bits are ignored.
- CYCLE at 0xFFF2:
  - Read returns the counter value.
  - Write loads `data` into the counter.
- Any other address:
  - Read returns 0.
  - Write has no effect.
  - Either access sets `fault`.

Rules:
- Every cycle is one access, so a read happens whenever `wren`=0. Addresses are always decoded.
- RAM writes are write-first: on a write cycle, `q_dmem` in the next cycle shows the written word.
- Writes to MMIO addresses give `q_dmem` = 0 in the next cycle.
- A push when the FIFO is full is dropped and sets overflow. `fault` is not affected.
- A pop occurs when `out_valid` & `out_ready`.
- Push and pop in the same cycle:
  - If full, both succeed and count is unchanged. Overflow is not set.
  - If empty, the push lands. `out_valid` rises the next cycle; there is no fall-through.
- Cycle counter:
  - 32-bit, increments every cycle and wraps from 0xFFFFFFFF to 0.
  - A CYCLE write takes priority over the increment: the loaded value is visible the next cycle, then increments.
- If a single STATUS write clears fault while the same cycle also faults, set wins. The same applies to overflow.
- RAM contents are not reset. Reading before writing returns X, and the bench must not do it.

## Timing
- Read latency: exactly 1 cycle from the address edge to `q_dmem`. No stalls and no handshake on the dmem side.
- A CYCLE read returns the counter value held at the edge where the address is sampled.
- A STATUS read reflects state before that edge's push or pop.
- `out_valid`, `out_data` and `fault` are registered outputs.
- Reset (`reset`=0, asynchronous) forces:
  - `q_dmem`=0, `out_valid`=0, `out_data`=0, `fault`=0.
  - Overflow=0, counter=0, FIFO pointers and count=0.
- Reset asserted mid-operation discards FIFO contents and any pending read.
- First valid read data appears one cycle after the first edge following reset deassertion.

## Structure
- Package `dmem_map_pkg` holds:
  - Address constants ADDR_OUT_DATA, ADDR_STATUS, ADDR_CYCLE.
  - STATUS bit indices.
  - The count field position.
- Sub-module `out_fifo`:
  - Parameterised by depth.
  - Push/pop with full/empty/count outputs and an overflow pulse.
  - Asynchronous active-low reset.
- The RAM is an inferred array inside `dmem_responder`. Decode, counter, status and the `q_dmem` register are also in the top.

## Test plan
- RAM path: write 0x12345678 to 5, read 5 → `q_dmem`=0x12345678 one cycle later. The write cycle's next-cycle `q_dmem` also equals 0x12345678.
- FIFO drain: with `out_ready`=0, push 1..8 → STATUS=0x0801 (full, count 8). A 9th push sets STATUS bit3. With `out_ready`=1, `out_data` is 1..8 on consecutive cycles, then `out_valid`=0.
- Full simultaneity: with the FIFO full and `out_ready`=1, push 0xAA → count stays 8, overflow stays 0, and 0xAA exits last.
- Counter: write CYCLE=0xFFFFFFFE, then read CYCLE on the next two cycles → 0xFFFFFFFE, then 0xFFFFFFFF. A read two cycles after that returns 1.
- Fault: read 0x8000 → `q_dmem`=0, `fault`=1. Write 0x4 to STATUS → `fault`=0 next cycle.
- Reset mid-drain: with 3 entries queued, pulse `reset` low → `out_valid`=0, STATUS read = 0x0002, counter restarts from 0.
